// File: rtl/rom_stream_reader.sv
// rom_stream_reader
// Address sequencer and output stage in front of a combinational ROM.
// A burst command (start_addr, len) is turned into a sequence of ROM reads.
// Each word is captured into a registered valid/ready output stage that
// supports full throughput and backpressure.
//
// Optional build macro: ROM_STREAM_CSUM_EN
//   When it is defined, a csum output holds the running modulo-2**DWIDTH sum
//   of the beats transferred in the current burst.

module rom_stream_reader #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH:0]   len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
`ifdef ROM_STREAM_CSUM_EN
    ,
    output logic [DWIDTH-1:0] csum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH:0]   remaining_q, remaining_d;
    logic [AWIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [DWIDTH-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;
    logic              xfer;
`ifdef ROM_STREAM_CSUM_EN
    logic [DWIDTH-1:0] csum_q, csum_d;
`endif

    // A beat leaves the output stage on any cycle where both sides agree.
    assign xfer = m_valid_q && m_ready;

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        remaining_d = remaining_q;
        rom_addr_d  = rom_addr_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;
`ifdef ROM_STREAM_CSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                // abort has no meaning here; a coincident start still wins.
                if (start) begin
                    busy_d = 1'b1;
`ifdef ROM_STREAM_CSUM_EN
                    csum_d = '0;
`endif
                    if (len != '0) begin
                        state_d     = S_RUN;
                        rom_addr_d  = start_addr;
                        remaining_d = len;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                    m_valid_d   = 1'b0;
                    m_last_d    = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    // Refill the output register whenever it is empty or being drained.
                    load = (remaining_q != '0) && (!m_valid_q || m_ready);
`ifdef ROM_STREAM_CSUM_EN
                    if (xfer) begin
                        csum_d = csum_q + m_data_q;
                    end
`endif
                    if (load) begin
                        m_data_d    = rom_dout;
                        m_valid_d   = 1'b1;
                        m_last_d    = (remaining_q == (AWIDTH+1)'(1));
                        rom_addr_d  = rom_addr_q + AWIDTH'(1);
                        remaining_d = remaining_q - (AWIDTH+1)'(1);
                    end else if (xfer) begin
                        m_valid_d = 1'b0;
                    end
                    if ((remaining_q == '0) && xfer && m_last_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (abort) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            rom_addr_q  <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ROM_STREAM_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rom_addr_q  <= rom_addr_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef ROM_STREAM_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = rom_addr_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
`ifdef ROM_STREAM_CSUM_EN
    assign csum     = csum_q;
`endif

endmodule
